// File: rtl/sent_tx_crc_sched.sv
// sent_tx_crc_sched: shares one SENT TX CRC generator between the fast and slow builders; SENT_TX_CRC_SCHED_RR_EN selects round-robin arbitration.
// Latency: ack SETTLE_CYCLES+1 cycles after grant (1 cycle for an illegal mode); one job per SETTLE_CYCLES+2 cycles.
// Backpressure: req/ack handshake; a losing requester keeps req high and is granted in a later IDLE cycle.
module sent_tx_crc_sched #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic        clk_tx,
  input  logic        reset_tx,
  input  logic        fast_req,
  input  logic [2:0]  fast_mode,
  input  logic [23:0] fast_data,
  output logic        fast_ack,
  output logic [5:0]  fast_crc,
  input  logic        slow_req,
  input  logic [2:0]  slow_mode,
  input  logic [23:0] slow_data,
  output logic        slow_ack,
  output logic [5:0]  slow_crc,
  output logic [2:0]  enable_crc_gen,
  output logic [23:0] data_gen_crc,
  input  logic [5:0]  crc_gen,
  output logic        busy,
  output logic        mode_err
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t           state;
  logic             grant_slow;
  logic [CNT_W-1:0] settle_cnt;

  logic             any_req;
  logic             pick_slow;
  logic             sel_legal;
  logic [2:0]       sel_mode;
  logic [23:0]      sel_data;
  logic [23:0]      sel_data_masked;
  logic [5:0]       crc_cap;

`ifdef SENT_TX_CRC_SCHED_RR_EN
  logic rr_ptr;  // 0 prefers fast, 1 prefers slow

  assign pick_slow = (fast_req && slow_req) ? rr_ptr : !fast_req;
`else
  assign pick_slow = !fast_req;
`endif

  assign any_req   = fast_req | slow_req;
  assign sel_mode  = pick_slow ? slow_mode : fast_mode;
  assign sel_data  = pick_slow ? slow_data : fast_data;
  assign sel_legal = pick_slow ? (slow_mode == 3'b100 || slow_mode == 3'b101)
                               : (fast_mode == 3'b001 || fast_mode == 3'b010 || fast_mode == 3'b011);

  always_comb begin
    sel_data_masked = sel_data;
    case (sel_mode)
      3'b011, 3'b100: sel_data_masked = {12'h000, sel_data[11:0]};
      3'b010:         sel_data_masked = {8'h00, sel_data[15:0]};
      default:        sel_data_masked = sel_data;
    endcase
  end

  // Only enhanced serial produces a 6-bit CRC; the rest are CRC-4 with the top bits forced low.
  assign crc_cap = (enable_crc_gen == 3'b101) ? crc_gen : {2'b00, crc_gen[3:0]};

  always_ff @(posedge clk_tx) begin
    if (reset_tx) begin
      state          <= IDLE;
      grant_slow     <= 1'b0;
      settle_cnt     <= '0;
      enable_crc_gen <= 3'b000;
      data_gen_crc   <= '0;
      fast_ack       <= 1'b0;
      fast_crc       <= '0;
      slow_ack       <= 1'b0;
      slow_crc       <= '0;
      busy           <= 1'b0;
      mode_err       <= 1'b0;
`ifdef SENT_TX_CRC_SCHED_RR_EN
      rr_ptr         <= 1'b0;
`endif
    end else begin
      fast_ack <= 1'b0;
      slow_ack <= 1'b0;
      mode_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_slow <= pick_slow;
            busy       <= 1'b1;
`ifdef SENT_TX_CRC_SCHED_RR_EN
            rr_ptr     <= !pick_slow;
`endif
            if (sel_legal) begin
              state          <= DRIVE;
              enable_crc_gen <= sel_mode;
              data_gen_crc   <= sel_data_masked;
              settle_cnt     <= CNT_W'(SETTLE_CYCLES - 1);
            end else begin
              // Illegal mode never touches the generator: answer at once with a zero CRC.
              state    <= RESP;
              mode_err <= 1'b1;
              if (pick_slow) begin
                slow_ack <= 1'b1;
                slow_crc <= '0;
              end else begin
                fast_ack <= 1'b1;
                fast_crc <= '0;
              end
            end
          end
        end
        DRIVE: begin
          if (settle_cnt == '0) begin
            state          <= RESP;
            enable_crc_gen <= 3'b000;
            data_gen_crc   <= '0;
            if (grant_slow) begin
              slow_ack <= 1'b1;
              slow_crc <= crc_cap;
            end else begin
              fast_ack <= 1'b1;
              fast_crc <= crc_cap;
            end
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
